// File: rtl/i2c_filter_pkg.sv
// ============================================================================
// i2c_filter_pkg : constants shared by the I2C line sample filter
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_filter_pkg;
  localparam logic LINE_IDLE    = 1'b1;
  localparam int   HIST_W       = 5;
  localparam int   GLITCH_CNT_W = 8;

  // True when every sample in the window agrees.
  function automatic logic hist_uniform(input logic [HIST_W-1:0] h);
    return (h == '0) || (h == '1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/i2c_sample_filter_maj5.sv
// ============================================================================
// generic__maj5 : generic 5-input majority cell (Y=1 when >=3 inputs are 1)
// Rev 1.0
// ============================================================================
`default_nettype none

module generic__maj5 (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  output logic Y
);
  assign Y = (A & B & C) | (A & B & D) | (A & B & E) | (A & C & D) | (A & C & E)
           | (A & D & E) | (B & C & D) | (B & C & E) | (B & D & E) | (C & D & E);
endmodule

`default_nettype wire

// File: rtl/i2c_sample_filter.sv
// ============================================================================
// i2c_sample_filter : sync + oversample + 5-tap majority filter for one I2C line
// Optional glitch counter: define I2C_SAMPLE_FILTER_GLITCH_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_sample_filter
  import i2c_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_i,
  input  logic                    en_i,
  input  logic [DIV_W-1:0]        div_i,
  output logic                    filt_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic                    tick_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [HIST_W-1:0]      hist_q, hist_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_w;
  logic                   tick_w;
  logic                   maj_w;

  assign sync_w = sync_q[SYNC_STAGES-1];
  // Gating by en_i also covers en_i dropping on what would have been a tick.
  assign tick_w = en_i && (cnt_q >= div_i);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    cnt_d  = (!en_i || tick_w) ? '0 : cnt_q + DIV_W'(1);
    hist_d = tick_w ? {hist_q[HIST_W-2:0], sync_w} : hist_q;
    filt_d = maj_w;
    rise_d = maj_w & ~filt_q;
    fall_d = ~maj_w & filt_q;
  end

  generic__maj5 u_maj5 (
    .A (hist_q[0]),
    .B (hist_q[1]),
    .C (hist_q[2]),
    .D (hist_q[3]),
    .E (hist_q[4]),
    .Y (maj_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
      cnt_q  <= '0;
      hist_q <= {HIST_W{LINE_IDLE}};
      filt_q <= LINE_IDLE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign tick_o = tick_w;

`ifdef I2C_SAMPLE_FILTER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;

  // Judged on the window as it will look after this tick's shift.
  always_comb begin
    gcnt_d = gcnt_q;
    if (tick_w && !hist_uniform(hist_d) && (gcnt_q != '1))
      gcnt_d = gcnt_q + GLITCH_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign glitch_cnt_o = gcnt_q;
`else
  assign glitch_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_sample_filter.sv
// ============================================================================
// tb_i2c_sample_filter : scoreboard bench with a sample-window reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_sample_filter;
  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             line_i = 1'b1;
  logic             en_i   = 1'b0;
  logic [DIV_W-1:0] div_i  = '0;
  logic             filt_o, rise_o, fall_o, tick_o;
  logic [7:0]       glitch_cnt_o;

  i2c_sample_filter #(.SYNC_STAGES(SYNC_STAGES), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_i       (line_i),
    .en_i         (en_i),
    .div_i        (div_i),
    .filt_o       (filt_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .tick_o       (tick_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       filt;
    logic       rise;
    logic       fall;
    logic       tick;
    logic [7:0] gcnt;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fall_seen = 0;
  int   rise_seen = 0;

  // Reference model: line delay, window of the last five samples, phase since last tick.
  bit   line_dly[$];
  bit   samples[$];
  bit   m_filt, m_rise, m_fall;
  int   m_phase;
  int   m_gcnt;

  function automatic void model_reset();
    line_dly = {};
    samples  = {};
    for (int i = 0; i < SYNC_STAGES; i++) line_dly.push_back(1'b1);
    for (int i = 0; i < 5; i++) samples.push_back(1'b1);
    m_filt  = 1'b1;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_phase = 0;
    m_gcnt  = 0;
  endfunction

  function automatic int ones();
    int n = 0;
    foreach (samples[i]) n += int'(samples[i]);
    return n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: advance the model over the edge using the inputs that were applied,
  // then apply new inputs and queue the outputs expected for this cycle.
  task automatic cycle(input bit ln, input bit en, input int dv, input bit rs);
    bit   sync_now, tick_now, maj;
    obs_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      sync_now = line_dly[SYNC_STAGES-1];
      tick_now = en_i && (m_phase >= int'(div_i));
      maj      = (ones() >= 3);
      m_rise   = maj && !m_filt;
      m_fall   = !maj && m_filt;
      m_filt   = maj;
      if (tick_now) begin
        samples.push_back(sync_now);
        void'(samples.pop_front());
        if (ones() != 0 && ones() != 5 && m_gcnt < 255) m_gcnt++;
      end
      m_phase = (!en_i || tick_now) ? 0 : m_phase + 1;
      line_dly.push_front(line_i);
      void'(line_dly.pop_back());
    end
    line_i = ln;
    en_i   = en;
    div_i  = DIV_W'(dv);
    rst_n  = rs;
    if (!rs) model_reset();
    e.filt = m_filt;
    e.rise = m_rise;
    e.fall = m_fall;
    e.tick = rs && en && (m_phase >= dv);
`ifdef I2C_SAMPLE_FILTER_GLITCH_CNT_EN
    e.gcnt = 8'(m_gcnt);
`else
    e.gcnt = 8'h00;
`endif
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    g = '{filt: filt_o, rise: rise_o, fall: fall_o, tick: tick_o, gcnt: glitch_cnt_o};
    if (rise_o === 1'b1) rise_seen++;
    if (fall_o === 1'b1) fall_seen++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got filt=%b rise=%b fall=%b tick=%b gcnt=%0d, expected filt=%b rise=%b fall=%b tick=%b gcnt=%0d",
                 $time, g.filt, g.rise, g.fall, g.tick, g.gcnt, e.filt, e.rise, e.fall, e.tick, e.gcnt);
      end
    end
  end

  initial begin
    int f0, r0, lvl, len, dv;
    bit en;
    model_reset();

    repeat (3) cycle(1, 0, 0, 0);
    repeat (20) cycle(1, 1, 3, 1);

    // Clean 1->0 step at div 3.
    f0 = fall_seen; r0 = rise_seen;
    repeat (30) cycle(0, 1, 3, 1);
    chk("clean_fall_pulses", fall_seen - f0, 1);
    chk("clean_fall_no_rise", rise_seen - r0, 0);
    chk("clean_fall_level", int'(filt_o), 0);

    // Short low pulses on an idle-high line at div 0.
    repeat (12) cycle(1, 1, 0, 1);
    f0 = fall_seen; r0 = rise_seen;
    cycle(0, 1, 0, 1);
    repeat (12) cycle(1, 1, 0, 1);
    repeat (2) cycle(0, 1, 0, 1);
    repeat (12) cycle(1, 1, 0, 1);
    chk("glitch_reject_fall", fall_seen - f0, 0);
    chk("glitch_reject_rise", rise_seen - r0, 0);
    repeat (3) cycle(0, 1, 0, 1);
    repeat (12) cycle(1, 1, 0, 1);
    chk("pulse3_fall", fall_seen - f0, 1);
    chk("pulse3_rise", rise_seen - r0, 1);

    // Prescaler: shrink div_i below the running count, then div 0.
    cycle(1, 0, 9, 1);
    repeat (6) cycle(1, 1, 9, 1);
    repeat (10) cycle(1, 1, 2, 1);
    repeat (5) cycle(1, 1, 0, 1);

    // Freeze with a mixed window, then resume.
    repeat (3) cycle(0, 1, 1, 1);
    f0 = fall_seen; r0 = rise_seen;
    repeat (50) cycle(1'($urandom_range(0, 1)), 0, 1, 1);
    chk("freeze_fall", fall_seen - f0, 0);
    chk("freeze_rise", rise_seen - r0, 0);
    repeat (40) cycle(1'($urandom_range(0, 1)), 1, 1, 1);

    // Asynchronous reset with the window at all zeros.
    repeat (12) cycle(0, 1, 0, 1);
    chk("pre_reset_level", int'(filt_o), 0);
    f0 = fall_seen; r0 = rise_seen;
    repeat (2) cycle(0, 1, 3, 0);
    chk("reset_level", int'(filt_o), 1);
    repeat (3) cycle(0, 1, 3, 1);
    chk("reset_release_rise", rise_seen - r0, 0);
    chk("reset_release_fall", fall_seen - f0, 0);

    // Randomised runs of line level, divider and enable.
    for (int n = 0; n < 250; n++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      dv  = $urandom_range(0, 3);
      en  = ($urandom_range(0, 15) != 0);
      repeat (len) cycle(lvl[0], en, dv, 1);
    end

    // Isolated single-sample glitches on a low line.
    repeat (12) cycle(0, 1, 0, 1);
    f0 = fall_seen; r0 = rise_seen;
    for (int n = 0; n < 300; n++) begin
      cycle(1, 1, 0, 1);
      repeat (7) cycle(0, 1, 0, 1);
    end
    chk("glitch_train_rise", rise_seen - r0, 0);
`ifdef I2C_SAMPLE_FILTER_GLITCH_CNT_EN
    chk("glitch_cnt_saturated", int'(glitch_cnt_o), 255);
`else
    chk("glitch_cnt_tied", int'(glitch_cnt_o), 0);
`endif

    cycle(0, 1, 0, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
